// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage and the SPI register block.
package pwm_pkg;

    localparam int unsigned    PWM_CNT_W       = 8;
    localparam logic [7:0]     PWM_DUTY_MAX    = 8'hFF;
    localparam int unsigned    NUM_OUT         = 16;
    localparam int unsigned    DEFAULT_CLK_DIV = 13;

    // Register addresses as seen by the SPI register block.
    localparam logic [7:0]     ADDR_EN_OUT_LO  = 8'd0;
    localparam logic [7:0]     ADDR_EN_OUT_HI  = 8'd1;
    localparam logic [7:0]     ADDR_EN_PWM_LO  = 8'd2;
    localparam logic [7:0]     ADDR_EN_PWM_HI  = 8'd3;
    localparam logic [7:0]     ADDR_DUTY       = 8'd4;

    // PWM level for a counter value against a duty value. Full scale duty
    // is forced high so that 255 really means 100 %.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        logic level;
        if (duty == PWM_DUTY_MAX) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick is high for one clk every CLK_DIV clks.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned     PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] prescaler_d;
    logic [PS_W-1:0] prescaler_q;

    // Next prescaler value: wrap to zero on the terminal count, else increment.
    always_comb begin
        tick        = (prescaler_q == PS_LAST);
        prescaler_d = prescaler_q;
        if (tick) begin
            prescaler_d = '0;
        end else begin
            prescaler_d = prescaler_q + PS_ONE;
        end
    end

    // Prescaler state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives the 16 user outputs as forced-low, static-high or a shared PWM
// waveform. The duty value is shadowed at the period wrap so a duty write
// never truncates or stretches a pulse; enable/mode bits act immediately.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CNT_W   = PWM_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_OUT-1:0]  out,
    output logic                period_start
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                tick_s;
    logic                wrap_s;
    logic                pwm_level_s;
    logic [NUM_OUT-1:0]  en_out_s;
    logic [NUM_OUT-1:0]  en_pwm_s;

    logic [CNT_W-1:0]    pwm_cnt_d,      pwm_cnt_q;
    logic [7:0]          duty_shadow_d,  duty_shadow_q;
    logic [NUM_OUT-1:0]  out_d,          out_q;
    logic                period_start_d, period_start_q;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // PWM counter advance and duty capture on the wrap edge.
    always_comb begin
        wrap_s        = tick_s && (pwm_cnt_q == CNT_MAX);
        pwm_cnt_d     = pwm_cnt_q;
        duty_shadow_d = duty_shadow_q;
        if (tick_s) begin
            pwm_cnt_d = pwm_cnt_q + CNT_ONE;
        end else begin
            pwm_cnt_d = pwm_cnt_q;
        end
        if (wrap_s) begin
            duty_shadow_d = pwm_duty_cycle;
        end else begin
            duty_shadow_d = duty_shadow_q;
        end
    end

    // Per-output mux: enable beats mode, mode picks static high or PWM.
    always_comb begin
        en_out_s       = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_s       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_level_s    = pwm_level(pwm_cnt_q, duty_shadow_q);
        period_start_d = wrap_s;
        out_d          = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (!en_out_s[i]) begin
                out_d[i] = 1'b0;
            end else if (en_pwm_s[i]) begin
                out_d[i] = pwm_level_s;
            end else begin
                out_d[i] = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any period in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            duty_shadow_q  <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=13 (3328 clk per period).
module tb_pwm_output_stage;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0  = 8'h00;
    logic [7:0]  en_reg_out_15_8 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0  = 8'h00;
    logic [7:0]  en_reg_pwm_15_8 = 8'h00;
    logic [7:0]  pwm_duty_cycle  = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int errors = 0;
    int checks = 0;

    pwm_output_stage #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Observe one full period starting on the cycle after a period_start
    // pulse; optionally write a new duty at sample index chg_at.
    task automatic measure(input int chg_at, input logic [7:0] chg_duty,
                           input logic [15:0] mask,
                           output int hi4, output int hi5, output int hi7,
                           output int chg4, output int stray,
                           output int ps_cnt, output logic ps_end);
        logic prev4;
        hi4 = 0; hi5 = 0; hi7 = 0; chg4 = 0; stray = 0; ps_cnt = 0;
        prev4 = out[4];
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (out[4]) hi4++;
            if (out[5]) hi5++;
            if (out[7]) hi7++;
            if (out[4] !== prev4) chg4++;
            prev4 = out[4];
            if ((out & ~mask) !== 16'h0000) stray++;
            if (period_start) ps_cnt++;
            if (i == chg_at) pwm_duty_cycle = chg_duty;
        end
        ps_end = period_start;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 16'h0000) begin
            errors++; $display("FAIL reset_out: got %h expected 0000", out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++; $display("FAIL reset_ps: got %b expected 0", period_start);
        end
        en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'h00;
        rst_n = 1'b1;
        n = 0; bad = 0;
        while (n < PERIOD + 100) begin
            @(negedge clk);
            n++;
            if (n >= 2 && out !== 16'hFFFF) bad++;
            if (period_start) break;
        end
        checks++;
        if (n !== PERIOD) begin
            errors++; $display("FAIL first_ps_cycle: got %0d expected %0d", n, PERIOD);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL static_high_after_reset: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_static_high();
        int hi4, hi5, hi7, chg4, stray, psc;
        logic pse;
        measure(-1, 8'h00, 16'hFFFF, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi7 !== PERIOD || hi4 !== PERIOD) begin
            errors++; $display("FAIL static_high: got %0d/%0d expected %0d", hi7, hi4, PERIOD);
        end
        checks++;
        if (psc !== 1 || pse !== 1'b1) begin
            errors++; $display("FAIL static_ps: got cnt=%0d end=%b expected 1/1", psc, pse);
        end
    endtask

    task automatic test_pwm_50();
        int hi4, hi5, hi7, chg4, stray, psc;
        logic pse;
        en_reg_out_7_0 = 8'hF0; en_reg_out_15_8 = 8'h00;
        en_reg_pwm_7_0 = 8'h30; en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle = 8'd128;
        measure(-1, 8'h00, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        // Duty 128 active here; queue duty 0 for the next period.
        measure(100, 8'd0, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== 1664 || hi5 !== 1664) begin
            errors++; $display("FAIL pwm50_high: got %0d/%0d expected 1664", hi4, hi5);
        end
        checks++;
        if (hi7 !== PERIOD) begin
            errors++; $display("FAIL pwm50_static: got %0d expected %0d", hi7, PERIOD);
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL pwm50_disabled_bits: got %0d expected 0", stray);
        end
        checks++;
        if (chg4 !== 2) begin
            errors++; $display("FAIL pwm50_edges: got %0d expected 2", chg4);
        end
        checks++;
        if (psc !== 1 || pse !== 1'b1) begin
            errors++; $display("FAIL pwm50_ps: got cnt=%0d end=%b expected 1/1", psc, pse);
        end
    endtask

    task automatic test_duty_extremes();
        int hi4, hi5, hi7, chg4, stray, psc;
        logic pse;
        measure(100, 8'd255, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== 0 || chg4 !== 0) begin
            errors++; $display("FAIL duty0: got high=%0d edges=%0d expected 0/0", hi4, chg4);
        end
        measure(-1, 8'h00, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== PERIOD) begin
            errors++; $display("FAIL duty255_first: got %0d expected %0d", hi4, PERIOD);
        end
        measure(100, 8'd64, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== PERIOD || chg4 !== 0) begin
            errors++; $display("FAIL duty255_second: got high=%0d edges=%0d expected %0d/0", hi4, chg4, PERIOD);
        end
    endtask

    task automatic test_mid_period_change();
        int hi4, hi5, hi7, chg4, stray, psc;
        logic pse;
        // Duty 64 active; write 192 when pwm_cnt=100 (sample 1300).
        measure(100 * CLK_DIV, 8'd192, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== 832) begin
            errors++; $display("FAIL mid_change_current: got %0d expected 832", hi4);
        end
        measure(100, 8'd128, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== 2496) begin
            errors++; $display("FAIL mid_change_next: got %0d expected 2496", hi4);
        end
        checks++;
        if (psc !== 1 || pse !== 1'b1) begin
            errors++; $display("FAIL mid_change_ps: got cnt=%0d end=%b expected 1/1", psc, pse);
        end
    endtask

    task automatic test_reset_mid_period();
        int hi4, hi5, hi7, chg4, stray, psc;
        logic pse;
        int n;
        int hi;
        // Duty 128 is active; move to pwm_cnt=200 and pulse reset.
        repeat (200 * CLK_DIV) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got out=%h ps=%b expected 0000/0", out, period_start);
        end
        rst_n = 1'b1;
        n = 0; hi = 0;
        while (n < PERIOD + 100) begin
            @(negedge clk);
            n++;
            if (out[4]) hi++;
            if (period_start) break;
        end
        checks++;
        if (n !== PERIOD) begin
            errors++; $display("FAIL mid_reset_restart: got %0d expected %0d", n, PERIOD);
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL mid_reset_first_low: got %0d expected 0", hi);
        end
        measure(-1, 8'h00, 16'h00F0, hi4, hi5, hi7, chg4, stray, psc, pse);
        checks++;
        if (hi4 !== 1664 || hi5 !== 1664) begin
            errors++; $display("FAIL mid_reset_second: got %0d/%0d expected 1664", hi4, hi5);
        end
    endtask

    task automatic test_enable_clear();
        int hi;
        en_reg_out_7_0 = 8'h18;
        en_reg_pwm_7_0 = 8'h18;
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (out[4]) hi++;
            if (i == 50) begin
                checks++;
                if (out[3] !== 1'b1) begin
                    errors++; $display("FAIL en_clear_before: got %b expected 1", out[3]);
                end
                en_reg_out_7_0 = 8'h10;
            end
            if (i == 51) begin
                checks++;
                if (out[3] !== 1'b0) begin
                    errors++; $display("FAIL en_clear_after: got %b expected 0", out[3]);
                end
            end
        end
        checks++;
        if (hi !== 1664) begin
            errors++; $display("FAIL en_clear_other_bit: got %0d expected 1664", hi);
        end
    endtask

    initial begin
        test_reset();
        test_static_high();
        test_pwm_50();
        test_duty_extremes();
        test_mid_period_change();
        test_reset_mid_period();
        test_enable_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
